// File: rtl/oram_request_scheduler.sv
// oram_request_scheduler
//   Front-end between a client valid/ready interface and the ORAM core.
//   Client requests are queued in a FIFO and issued to the core one at a time,
//   so the core never has more than one operation outstanding. Each result is
//   returned to the client with the request's tag, and as an error if the core
//   does not complete within TIMEOUT cycles.
// Ports
//   clk, rst_n                       : clock, asynchronous active-low reset
//   req_valid/req_ready              : request handshake
//   req_rw/addr/wdata/tag            : request payload (rw: 0=read, 1=write)
//   resp_valid/resp_ready            : response handshake
//   resp_rdata/rw/tag/err            : response payload
//   rw_block_number, w_value,
//   rw_indicator, input_ready        : issue side to the core
//   r_value, output_ready            : completion side from the core
//   fifo_count                       : request FIFO occupancy

package oramPkg;
  localparam int d = 8;
  localparam int a = 4;
endpackage

module oram_request_scheduler #(
  parameter int D       = oramPkg::d,
  parameter int A       = oramPkg::a,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_rw,
  input  logic [D-1:0]               req_addr,
  input  logic [8*A-1:0]             req_wdata,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [8*A-1:0]             resp_rdata,
  output logic                       resp_rw,
  output logic [TAG_W-1:0]           resp_tag,
  output logic                       resp_err,
  output logic [D-1:0]               rw_block_number,
  output logic [8*A-1:0]             w_value,
  output logic                       rw_indicator,
  output logic                       input_ready,
  input  logic [8*A-1:0]             r_value,
  input  logic                       output_ready,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 8 * A;
  localparam int EW = 1 + D + DW + TAG_W;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Request FIFO
  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  logic             h_rw;
  logic [D-1:0]     h_addr;
  logic [DW-1:0]    h_wdata;
  logic [TAG_W-1:0] h_tag;

  // FSM / response
  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic             tmo;

  logic [D-1:0]     blk_q;
  logic [DW-1:0]    wval_q;
  logic             rwi_q;
  logic [DW-1:0]    rdata_q;
  logic             rrw_q;
  logic [TAG_W-1:0] rtag_q;
  logic             rerr_q;

  assign req_ready = rst_n && (count_q < CW'(DEPTH));
  assign push      = req_valid && req_ready;
  // ISSUE is only entered with a non-empty FIFO and is the sole consumer.
  assign pop       = (state_q == S_ISSUE);

  assign {h_rw, h_addr, h_wdata, h_tag} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_rw, req_addr, req_wdata, req_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo     = 1'b0;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
      S_ISSUE: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        wait_d = wait_q + TW'(1);
        if (output_ready) begin
          state_d = S_RESP;
        end else if (wait_d == TW'(TIMEOUT)) begin
          tmo     = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      blk_q   <= '0;
      wval_q  <= '0;
      rwi_q   <= 1'b0;
      rdata_q <= '0;
      rrw_q   <= 1'b0;
      rtag_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      // Core-side outputs are registered: loading them on the IDLE->ISSUE
      // edge puts the head on the bus for exactly the ISSUE cycle and holds
      // it afterwards.
      if (state_q == S_IDLE && state_d == S_ISSUE) begin
        blk_q  <= h_addr;
        wval_q <= h_wdata;
        rwi_q  <= h_rw;
      end
      if (state_q == S_ISSUE) begin
        rrw_q  <= h_rw;
        rtag_q <= h_tag;
      end
      if (state_q == S_WAIT) begin
        if (output_ready) begin
          rdata_q <= rrw_q ? '0 : r_value;
          rerr_q  <= 1'b0;
        end else if (tmo) begin
          rdata_q <= '0;
          rerr_q  <= 1'b1;
        end
      end
    end
  end

  assign input_ready     = (state_q == S_ISSUE);
  assign resp_valid      = (state_q == S_RESP);
  assign rw_block_number = blk_q;
  assign w_value         = wval_q;
  assign rw_indicator    = rwi_q;
  assign resp_rdata      = rdata_q;
  assign resp_rw         = rrw_q;
  assign resp_tag        = rtag_q;
  assign resp_err        = rerr_q;
  assign fifo_count      = count_q;

endmodule
